// File: rtl/bar_graph_history_plotter_pkg.sv
// Shared definitions for the bar graph history plotter: FSM encoding, VGA port widths,
// colour constants and the height clip helper.
package bar_graph_history_plotter_pkg;

  localparam int X_W   = 9;
  localparam int Y_W   = 8;
  localparam int COL_W = 3;
  localparam int H_W   = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DRAW  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [COL_W-1:0] COL_BLACK = 3'b000;
  localparam logic [COL_W-1:0] COL_GREEN = 3'b010;

  function automatic logic [H_W-1:0] clip_height(input logic [H_W-1:0] value,
                                                 input logic [H_W-1:0] max_h);
    return (value > max_h) ? max_h : value;
  endfunction

endpackage

// File: rtl/bar_graph_history_plotter_history.sv
// History of the last NUM_BARS sample heights: shift-left on write (slot 0 oldest),
// clipped write into the newest slot, random read port and a non-zero mask.
module bar_history_shift
  import bar_graph_history_plotter_pkg::*;
#(
  parameter int NUM_BARS = 8,
  parameter int MAX_H    = 100,
  parameter int IDX_W    = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                wr_en,
  input  logic [H_W-1:0]      wr_value,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [H_W-1:0]      rd_value,
  output logic [NUM_BARS-1:0] nz_mask
);

  logic [H_W-1:0] hist_q [NUM_BARS];
  logic [H_W-1:0] hist_d [NUM_BARS];

  always_comb begin
    hist_d = hist_q;
    if (wr_en) begin
      for (int k = 0; k < NUM_BARS - 1; k++) begin
        hist_d[k] = hist_q[k+1];
      end
      hist_d[NUM_BARS-1] = clip_height(wr_value, H_W'(MAX_H));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NUM_BARS; k++) begin
        hist_q[k] <= '0;
      end
    end else begin
      hist_q <= hist_d;
    end
  end

  always_comb begin
    rd_value = '0;
    nz_mask  = '0;
    for (int k = 0; k < NUM_BARS; k++) begin
      if (rd_idx == IDX_W'(k)) begin
        rd_value = hist_q[k];
      end
      nz_mask[k] = |hist_q[k];
    end
  end

endmodule

// File: rtl/bar_graph_history_plotter.sv
// Redraws a bar graph of the sample history on every accepted sample: clears the graph
// area, then draws each bar pixel by pixel, one registered pixel per cycle.
//
// state    | meaning
// ST_IDLE  | waiting for a sample, sample_ready high
// ST_CLEAR | emitting background pixels of the W_TOT x MAX_H area
// ST_DRAW  | emitting pixels of bar bar_q (zero-height bars are skipped)
// ST_DONE  | one-cycle frame_done pulse, no pixel
module bar_graph_history_plotter
  import bar_graph_history_plotter_pkg::*;
#(
  parameter int               NUM_BARS = 8,
  parameter int               BAR_W    = 8,
  parameter int               GAP      = 2,
  parameter int               ORIGIN_X = 40,
  parameter int               BASE_Y   = 200,
  parameter int               MAX_H    = 100,
  parameter logic [COL_W-1:0] BAR_COL  = COL_GREEN,
  parameter logic [COL_W-1:0] BG_COL   = COL_BLACK
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sample_valid,
  input  logic [H_W-1:0]   sample_value,
  output logic             sample_ready,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [COL_W-1:0] colour,
  output logic             plot,
  output logic             busy,
  output logic             frame_done
);

  localparam int PITCH = BAR_W + GAP;
  localparam int W_TOT = NUM_BARS * PITCH;
  localparam int CNT_W = (W_TOT > 1) ? $clog2(W_TOT) : 1;
  localparam int ROW_W = (MAX_H > 1) ? $clog2(MAX_H) : 1;
  localparam int IDX_W = $clog2(NUM_BARS + 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] bar_q, bar_d;
  logic [X_W-1:0]   xbase_q, xbase_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [COL_W-1:0] colour_q, colour_d;
  logic             plot_q, plot_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic                wr_en;
  logic [H_W-1:0]      cur_h;
  logic [NUM_BARS-1:0] nz_mask;

  logic [IDX_W-1:0] srch_start, nxt_idx;
  logic [X_W-1:0]   srch_base, run_base, nxt_base;
  logic             nxt_found;
  logic             in_bar, last_col, last_row;

  bar_history_shift #(
    .NUM_BARS (NUM_BARS),
    .MAX_H    (MAX_H),
    .IDX_W    (IDX_W)
  ) u_history (
    .clk      (clk),
    .resetn   (resetn),
    .wr_en    (wr_en),
    .wr_value (sample_value),
    .rd_idx   (bar_q),
    .rd_value (cur_h),
    .nz_mask  (nz_mask)
  );

  // Next non-empty bar after the current one; the base advances one pitch per skipped bar.
  always_comb begin
    srch_start = (state_q == ST_DRAW) ? bar_q + IDX_W'(1) : '0;
    srch_base  = (state_q == ST_DRAW) ? xbase_q + X_W'(PITCH) : X_W'(ORIGIN_X);
    run_base   = srch_base;
    nxt_base   = srch_base;
    nxt_idx    = '0;
    nxt_found  = 1'b0;
    for (int k = 0; k < NUM_BARS; k++) begin
      if (!nxt_found && (IDX_W'(k) >= srch_start)) begin
        if (nz_mask[k]) begin
          nxt_found = 1'b1;
          nxt_idx   = IDX_W'(k);
          nxt_base  = run_base;
        end else begin
          run_base = run_base + X_W'(PITCH);
        end
      end
    end
  end

  always_comb begin
    in_bar   = (state_q == ST_DRAW);
    last_col = in_bar ? (col_q == CNT_W'(BAR_W - 1)) : (col_q == CNT_W'(W_TOT - 1));
    last_row = in_bar ? ((8'(row_q) + 8'd1) == {1'b0, cur_h})
                      : (row_q == ROW_W'(MAX_H - 1));
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    bar_d    = bar_q;
    xbase_d  = xbase_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    busy_d   = 1'b0;
    ready_d  = 1'b0;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (sample_valid) begin
          wr_en    = 1'b1;
          state_d  = ST_CLEAR;
          col_d    = '0;
          row_d    = '0;
          ready_d  = 1'b0;
          plot_d   = 1'b1;
          busy_d   = 1'b1;
          x_d      = X_W'(ORIGIN_X);
          y_d      = Y_W'(BASE_Y);
          colour_d = BG_COL;
        end
      end
      ST_CLEAR, ST_DRAW: begin
        if (!last_col) begin
          col_d = col_q + CNT_W'(1);
        end else if (!last_row) begin
          col_d = '0;
          row_d = row_q + ROW_W'(1);
        end else if (nxt_found) begin
          state_d = ST_DRAW;
          bar_d   = nxt_idx;
          xbase_d = nxt_base;
          col_d   = '0;
          row_d   = '0;
        end else begin
          state_d = ST_DONE;
        end
        if (state_d == ST_DONE) begin
          done_d = 1'b1;
        end else begin
          plot_d   = 1'b1;
          busy_d   = 1'b1;
          colour_d = (state_d == ST_DRAW) ? BAR_COL : BG_COL;
          x_d      = ((state_d == ST_DRAW) ? xbase_d : X_W'(ORIGIN_X)) + X_W'(col_d);
          y_d      = Y_W'(BASE_Y) - Y_W'(row_d);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      bar_q    <= '0;
      xbase_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      bar_q    <= bar_d;
      xbase_q  <= xbase_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign sample_ready = ready_q;
  assign x            = x_q;
  assign y            = y_q;
  assign colour       = colour_q;
  assign plot         = plot_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_bar_graph_history_plotter.sv
// Scoreboard bench for the bar graph plotter: a posedge observer pushes the modelled frame
// on every accept, a negedge monitor pops and compares every plotted pixel.
module tb_bar_graph_history_plotter;

  localparam int NB = 4;
  localparam int BW = 2;
  localparam int GP = 1;
  localparam int OX = 10;
  localparam int BY = 20;
  localparam int MH = 4;
  localparam int WT = NB * (BW + GP);

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       sample_valid = 1'b0;
  logic [6:0] sample_value = '0;
  logic       sample_ready;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       frame_done;

  bar_graph_history_plotter #(
    .NUM_BARS (NB),
    .BAR_W    (BW),
    .GAP      (GP),
    .ORIGIN_X (OX),
    .BASE_Y   (BY),
    .MAX_H    (MH),
    .BAR_COL  (3'b010),
    .BG_COL   (3'b000)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .sample_valid (sample_valid),
    .sample_value (sample_value),
    .sample_ready (sample_ready),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .plot         (plot),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [19:0] exp_q[$];
  int          len_q[$];
  int          m_hist[NB];
  int          run = 0;
  int          last_len = 0;
  int          cyc = 0;
  int          done_cyc = 0;
  int          acc_cnt = 0;
  int          acc_cyc = 0;
  int          acc0 = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_accept(input int v);
    int total;
    for (int k = 0; k < NB - 1; k++) m_hist[k] = m_hist[k+1];
    m_hist[NB-1] = (v > MH) ? MH : v;
    total = 0;
    for (int r = 0; r < MH; r++)
      for (int c = 0; c < WT; c++) begin
        exp_q.push_back({9'(OX + c), 8'(BY - r), 3'b000});
        total++;
      end
    for (int i = 0; i < NB; i++)
      for (int r = 0; r < m_hist[i]; r++)
        for (int c = 0; c < BW; c++) begin
          exp_q.push_back({9'(OX + i * (BW + GP) + c), 8'(BY - r), 3'b010});
          total++;
        end
    len_q.push_back(total);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (resetn && sample_valid && sample_ready) begin
      acc_cnt++;
      acc_cyc = cyc;
      model_accept(int'(sample_value));
    end
  end

  always @(negedge clk) begin
    if (!resetn) begin
      run = 0;
    end else begin
      if (plot) begin
        logic [19:0] e;
        if (!busy) chk("plot_without_busy", 1, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", 1, 0);
        end else begin
          e = exp_q.pop_front();
          tests++;
          if ({x, y, colour} !== e) begin
            fails++;
            $display("FAIL pixel: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                     x, y, colour, e[19:11], e[10:3], e[2:0]);
          end
        end
        run++;
      end else if (frame_done) begin
        if (len_q.size() == 0) chk("unexpected_frame_done", 1, 0);
        else chk("frame_plot_cycles", run, len_q.pop_front());
        chk("pixels_left_at_done", exp_q.size(), 0);
        last_len = run;
        done_cyc = cyc;
        run = 0;
      end else if (run != 0) begin
        chk("gap_in_plot_stream", 1, 0);
        run = 0;
      end
      if (busy) chk("ready_low_while_busy", int'(sample_ready), 0);
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    resetn = 1'b0;
    sample_valid = 1'b0;
    exp_q.delete();
    len_q.delete();
    for (int k = 0; k < NB; k++) m_hist[k] = 0;
    #1;
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(sample_ready), 1);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_xyc", int'({x, y, colour}), 0);
    @(posedge clk);
    #1;
    chk("rst_next_plot", int'(plot), 0);
    chk("rst_next_ready", int'(sample_ready), 1);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic send(input int v);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sample_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("ready_timeout", 0, 1);
    sample_value = 7'(v);
    sample_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (frame_done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("frame_done_timeout", 0, 1);
  endtask

  initial begin
    do_reset();

    // reset mid-frame, then an all-zero history
    send(2);
    repeat (10) @(negedge clk);
    do_reset();
    send(0);
    wait_done();
    chk("zero_sample_len", last_len, 48);

    send(3);
    wait_done();
    chk("sample3_after_zero_len", last_len, 54);

    do_reset();
    send(3);
    wait_done();
    chk("sample3_len", last_len, 54);

    send(100);
    wait_done();
    chk("clip_len", last_len, 62);

    for (int v = 1; v <= 4; v++) begin
      send(v);
      wait_done();
    end
    chk("seq_1234_len", last_len, 68);

    // sample held through a redraw
    send(1);
    @(negedge clk);
    sample_value = 7'd2;
    sample_valid = 1'b1;
    acc0 = acc_cnt;
    wait_done();
    for (int i = 0; i < 20; i++) begin
      if (acc_cnt != acc0) break;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    chk("held_accept_seen", int'(acc_cnt != acc0), 1);
    chk("held_accept_cycle", acc_cyc - done_cyc, 2);
    wait_done();
    repeat (5) @(negedge clk);
    chk("held_accept_once", acc_cnt - acc0, 1);
    chk("held_frame_len", last_len, 68);
    chk("idle_ready_end", int'(sample_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
